// File: rtl/overlay_pkg.sv
// overlay_pkg
//   Shared definitions for the overlay mixer: 6-bit colour constants in
//   {R[1:0],G[1:0],B[1:0]} format, the blend level range and the fade FSM
//   state encoding.
//   No ports (package).
package overlay_pkg;

   // Colour constants, {R[1:0],G[1:0],B[1:0]}
   localparam logic [5:0] KEY_COLOR = 6'b100001;  // overlay transparency key
   localparam logic [5:0] BLACK     = 6'b000000;
   localparam logic [5:0] WHITE     = 6'b111111;
   localparam logic [5:0] GOLD      = 6'b111100;
   localparam logic [5:0] RED       = 6'b110000;

   // Blend level runs 0 (overlay invisible) .. 4 (overlay opaque)
   localparam logic [2:0] LEVEL_MIN = 3'd0;
   localparam logic [2:0] LEVEL_MAX = 3'd4;

   typedef enum logic [1:0] {
      HIDDEN   = 2'd0,
      FADE_IN  = 2'd1,
      SHOWN    = 2'd2,
      FADE_OUT = 2'd3
   } fade_state_t;

   function automatic logic is_fading(input fade_state_t s);
      return (s == FADE_IN) || (s == FADE_OUT);
   endfunction

endpackage

// File: rtl/overlay_mixer_channel_blend.sv
// channel_blend
//   Combinational blend of one 2-bit colour channel:
//     out = (ov*level + bg*(4-level)) >> 2, 5-bit arithmetic, truncated.
//   Ports:
//     ov    [1:0] in  : overlay channel value
//     bg    [1:0] in  : background channel value
//     level [2:0] in  : blend level, 0..4
//     out   [1:0] out : blended channel value
module channel_blend (
   input  logic [1:0] ov,
   input  logic [1:0] bg,
   input  logic [2:0] level,
   output logic [1:0] out
);

   logic [2:0] bg_weight;
   logic [4:0] ov_term;
   logic [4:0] bg_term;
   logic [4:0] sum;

   // The two weights always add up to 4, so the sum never exceeds 12 and
   // level 4 reproduces ov exactly.
   assign bg_weight = 3'd4 - level;
   assign ov_term   = {3'b000, ov} * {2'b00, level};
   assign bg_term   = {3'b000, bg} * {2'b00, bg_weight};
   assign sum       = ov_term + bg_term;
   assign out       = 2'(sum >> 2);

endmodule

// File: rtl/overlay_mixer.sv
// overlay_mixer
//   Composites an overlay emblem onto a background video stream with a
//   frame-paced fade in / fade out. The fade level steps by one every
//   FRAMES_PER_STEP frames (frame = rising edge of vsync_in). Pixels equal
//   to KEY_COLOR are transparent. All outputs are registered; rgb, hsync and
//   vsync lag their inputs by exactly one clock.
//   Ports:
//     clk        in   pixel clock
//     rst_n      in   asynchronous active-low reset
//     hsync_in   in   horizontal sync, high = pulse
//     vsync_in   in   vertical sync, high = pulse
//     active_in  in   visible-area flag aligned with bg_rgb/ov_rgb
//     bg_rgb     in   [5:0] background pixel
//     ov_rgb     in   [5:0] overlay pixel, KEY_COLOR = transparent
//     show       in   1 = overlay requested visible, 0 = hidden
//     rgb        out  [5:0] composited pixel
//     hsync      out  hsync_in delayed one clock
//     vsync      out  vsync_in delayed one clock
//     fade_level out  [2:0] current blend level 0..4
//     busy       out  high while fading in or out
//     state_dbg  out  [1:0] fade FSM state (overlay_pkg::fade_state_t)
//
//   Handshake: none. Every input is sampled on every clock; there is no
//   valid/ready flow control, the pixel stream is free-running.
module overlay_mixer #(
   parameter int unsigned FRAMES_PER_STEP = 4,
   parameter logic [5:0]  KEY_COLOR       = overlay_pkg::KEY_COLOR
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       active_in,
   input  logic [5:0] bg_rgb,
   input  logic [5:0] ov_rgb,
   input  logic       show,
   output logic [5:0] rgb,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] fade_level,
   output logic       busy,
   output logic [1:0] state_dbg
);

   import overlay_pkg::*;

   localparam logic [3:0] STEP_LAST = 4'(FRAMES_PER_STEP - 1);

   fade_state_t state_q, state_d;
   logic [2:0]  level_q, level_d;
   logic [3:0]  frame_cnt_q, frame_cnt_d;
   logic        vsync_hist_q;
   logic        vsync_armed_q;
   logic        frame_tick;
   logic [5:0]  blend_rgb;
   logic [5:0]  pixel_d;

   // ------------------------------------------------------------------
   // Frame tick
   // ------------------------------------------------------------------
   // The history flop resets to 0, which on its own would turn a vsync_in
   // that is already high at reset release into a bogus edge. The armed
   // flag stays low until vsync_in has been seen low once, so the first
   // tick after reset always needs a genuine 0->1 transition.
   assign frame_tick = vsync_in & ~vsync_hist_q & vsync_armed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_hist_q  <= 1'b0;
         vsync_armed_q <= 1'b0;
      end else begin
         vsync_hist_q <= vsync_in;
         if (!vsync_in) begin
            vsync_armed_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Fade FSM, level and frame counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HIDDEN;
         level_q     <= LEVEL_MIN;
         frame_cnt_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // A show-driven direction change wins over a coincident tick: the level
   // is kept and the frame count restarts. The final step of a fade and
   // the move to SHOWN/HIDDEN happen on the same tick.
   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      frame_cnt_d = frame_cnt_q;

      unique case (state_q)
         HIDDEN: begin
            if (show) begin
               state_d = FADE_IN;
            end
         end

         FADE_IN: begin
            if (!show) begin
               state_d = FADE_OUT;
            end else if (level_q >= LEVEL_MAX) begin
               state_d = SHOWN;
            end else if (frame_tick) begin
               if (frame_cnt_q >= STEP_LAST) begin
                  frame_cnt_d = 4'd0;
                  level_d     = level_q + 3'd1;
                  if (level_q == LEVEL_MAX - 3'd1) begin
                     state_d = SHOWN;
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + 4'd1;
               end
            end
         end

         SHOWN: begin
            if (!show) begin
               state_d = FADE_OUT;
            end
         end

         FADE_OUT: begin
            if (show) begin
               state_d = FADE_IN;
            end else if (level_q == LEVEL_MIN) begin
               state_d = HIDDEN;
            end else if (frame_tick) begin
               if (frame_cnt_q >= STEP_LAST) begin
                  frame_cnt_d = 4'd0;
                  level_d     = level_q - 3'd1;
                  if (level_q == LEVEL_MIN + 3'd1) begin
                     state_d = HIDDEN;
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + 4'd1;
               end
            end
         end

         default: begin
            state_d = HIDDEN;
         end
      endcase

      if (state_d != state_q) begin
         frame_cnt_d = 4'd0;
      end
   end

   // ------------------------------------------------------------------
   // Pixel path
   // ------------------------------------------------------------------
   channel_blend u_blend_r (
      .ov    (ov_rgb[5:4]),
      .bg    (bg_rgb[5:4]),
      .level (level_q),
      .out   (blend_rgb[5:4])
   );

   channel_blend u_blend_g (
      .ov    (ov_rgb[3:2]),
      .bg    (bg_rgb[3:2]),
      .level (level_q),
      .out   (blend_rgb[3:2])
   );

   channel_blend u_blend_b (
      .ov    (ov_rgb[1:0]),
      .bg    (bg_rgb[1:0]),
      .level (level_q),
      .out   (blend_rgb[1:0])
   );

   // Blend uses the level held during the sampled pixel, not level_d.
   always_comb begin
      pixel_d = blend_rgb;
      if (!active_in) begin
         pixel_d = BLACK;
      end else if ((ov_rgb == KEY_COLOR) || (level_q == LEVEL_MIN)) begin
         pixel_d = bg_rgb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb   <= BLACK;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else begin
         rgb   <= pixel_d;
         hsync <= hsync_in;
         vsync <= vsync_in;
      end
   end

   assign fade_level = level_q;
   assign busy       = is_fading(state_q);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_overlay_mixer.sv
// tb_overlay_mixer
//   Directed bench for overlay_mixer with FRAMES_PER_STEP = 2. A reference
//   model tracks the fade as "requested direction + fading flag + level"
//   and predicts the registered outputs; a compare process checks them on
//   every falling clock edge. Hand-computed literals pin key points.
module tb_overlay_mixer;

   import overlay_pkg::*;

   localparam int FPS = 2;

   // ------------------------------------------------------------------
   // Clock / reset and DUT
   // ------------------------------------------------------------------
   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       hsync_in  = 1'b0;
   logic       vsync_in  = 1'b0;
   logic       active_in = 1'b0;
   logic [5:0] bg_rgb    = 6'd0;
   logic [5:0] ov_rgb    = 6'd0;
   logic       show      = 1'b0;
   logic [5:0] rgb;
   logic       hsync;
   logic       vsync;
   logic [2:0] fade_level;
   logic       busy;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   overlay_mixer #(
      .FRAMES_PER_STEP (FPS),
      .KEY_COLOR       (KEY_COLOR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .active_in  (active_in),
      .bg_rgb     (bg_rgb),
      .ov_rgb     (ov_rgb),
      .show       (show),
      .rgb        (rgb),
      .hsync      (hsync),
      .vsync      (vsync),
      .fade_level (fade_level),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   // ------------------------------------------------------------------
   // Scoreboard counters
   // ------------------------------------------------------------------
   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   int         m_lvl     = 0;
   bit         m_up      = 1'b0;  // direction last requested by show
   bit         m_fading  = 1'b0;
   int         m_frames  = 0;
   bit         m_prev_vs = 1'b1;  // "high" until vsync is seen low
   logic [5:0] exp_rgb   = 6'd0;
   logic       exp_hs    = 1'b0;
   logic       exp_vs    = 1'b0;

   function automatic logic [5:0] mix(input logic act, input logic [5:0] bg,
                                      input logic [5:0] ov, input int lvl);
      logic [5:0] r;
      int         o;
      int         b;
      r = 6'd0;
      if (!act) return 6'd0;
      if (ov == KEY_COLOR || lvl == 0) return bg;
      for (int ch = 0; ch < 3; ch++) begin
         o = int'(ov[2*ch +: 2]);
         b = int'(bg[2*ch +: 2]);
         r[2*ch +: 2] = 2'((o * lvl + b * (4 - lvl)) / 4);
      end
      return r;
   endfunction

   initial begin
      bit is_tick;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_lvl = 0; m_up = 1'b0; m_fading = 1'b0; m_frames = 0;
            m_prev_vs = 1'b1;
            exp_rgb = 6'd0; exp_hs = 1'b0; exp_vs = 1'b0;
         end else begin
            exp_rgb = mix(active_in, bg_rgb, ov_rgb, m_lvl);
            exp_hs  = hsync_in;
            exp_vs  = vsync_in;
            is_tick = vsync_in && !m_prev_vs;
            m_prev_vs = vsync_in;
            if (show != m_up) begin
               m_up = show; m_fading = 1'b1; m_frames = 0;
            end else if (m_fading) begin
               if (m_lvl == (m_up ? 4 : 0)) begin
                  m_fading = 1'b0;
               end else if (is_tick) begin
                  m_frames++;
                  if (m_frames == FPS) begin
                     m_frames = 0;
                     m_lvl += m_up ? 1 : -1;
                     if (m_lvl == (m_up ? 4 : 0)) m_fading = 1'b0;
                  end
               end
            end
         end
      end
   end

   // Compare process: outputs are stable at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("rgb",        int'(rgb),        int'(exp_rgb));
            check("hsync",      int'(hsync),      int'(exp_hs));
            check("vsync",      int'(vsync),      int'(exp_vs));
            check("fade_level", int'(fade_level), m_lvl);
            check("busy",       int'(busy),       int'(m_fading));
         end
      end
   end

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   logic [5:0] bg_tbl [6] = '{6'b000011, 6'b111111, 6'b010101, 6'b000000, 6'b101010, 6'b110001};
   logic [5:0] ov_tbl [6] = '{WHITE, GOLD, KEY_COLOR, RED, 6'b010110, 6'b101001};
   int         pix_idx = 0;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // One 5-clock frame: vsync high for 2 clocks, a short hsync pattern,
   // one blanked pixel, pixel data cycling through the tables.
   task automatic frame();
      for (int c = 0; c < 5; c++) begin
         vsync_in  = (c < 2);
         hsync_in  = (c == 0) || (c == 3);
         active_in = (c != 4);
         bg_rgb    = bg_tbl[pix_idx];
         ov_rgb    = ov_tbl[pix_idx];
         pix_idx   = (pix_idx + 1) % 6;
         step(1);
      end
      vsync_in = 1'b0;
      hsync_in = 1'b0;
   endtask

   task automatic frames(input int n);
      repeat (n) frame();
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   int lv_tbl   [10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4};
   int busy_tbl [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};

   initial begin
      // Reset state
      step(2);
      check("rst_rgb",   int'(rgb),        0);
      check("rst_hsync", int'(hsync),      0);
      check("rst_vsync", int'(vsync),      0);
      check("rst_level", int'(fade_level), 0);
      check("rst_busy",  int'(busy),       0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Hidden: background passes through unchanged
      show = 1'b0; active_in = 1'b1; bg_rgb = 6'b000011; ov_rgb = 6'b110110;
      step(1);
      check("hidden_rgb",   int'(rgb),        6'b000011);
      check("hidden_level", int'(fade_level), 0);
      check("hidden_busy",  int'(busy),       0);

      // Fade in over 10 frames
      show = 1'b1;
      step(2);
      check("fadein_busy", int'(busy), 1);
      for (int t = 0; t < 10; t++) begin
         frame();
         check($sformatf("fadein_lvl_tick%0d", t + 1), int'(fade_level), lv_tbl[t]);
         check($sformatf("fadein_busy_tick%0d", t + 1), int'(busy), busy_tbl[t]);
      end

      // Level 4: blanking forces black, syncs delayed by one clock
      active_in = 1'b0; ov_rgb = WHITE; bg_rgb = 6'b000011; hsync_in = 1'b1;
      step(1);
      check("blank_rgb",   int'(rgb),   0);
      check("blank_hsync", int'(hsync), 1);
      hsync_in = 1'b0; vsync_in = 1'b1;
      step(1);
      check("delay_hsync", int'(hsync), 0);
      check("delay_vsync", int'(vsync), 1);
      vsync_in = 1'b0; active_in = 1'b1; ov_rgb = WHITE; bg_rgb = 6'b000000;
      step(1);
      check("full_rgb",   int'(rgb),   6'b111111);
      check("fall_vsync", int'(vsync), 0);

      // Reset, fade in to level 2, blend checks
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      show  = 1'b1;
      step(2);
      frames(4);
      check("lvl2", int'(fade_level), 2);
      active_in = 1'b1; bg_rgb = 6'b000000; ov_rgb = 6'b111111;
      step(1);
      check("blend_lvl2", int'(rgb), 6'b010101);
      ov_rgb = KEY_COLOR; bg_rgb = 6'b001011;
      step(1);
      check("key_lvl2", int'(rgb), 6'b001011);

      // Level 3 in FADE_IN, drop show, fade back down
      frames(2);
      check("lvl3",      int'(fade_level), 3);
      check("lvl3_busy", int'(busy),       1);
      show = 1'b0;
      step(1);
      check("rev_lvl",  int'(fade_level), 3);
      check("rev_busy", int'(busy),       1);
      frames(2);
      check("out_lvl2", int'(fade_level), 2);
      frames(2);
      check("out_lvl1", int'(fade_level), 1);
      frames(2);
      check("out_lvl0",  int'(fade_level), 0);
      check("out_busy0", int'(busy),       0);

      // Reset mid-frame at level 2 with vsync_in held high through release
      show = 1'b1;
      step(2);
      frames(4);
      check("pre_rst_lvl", int'(fade_level), 2);
      vsync_in = 1'b1;
      step(1);
      rst_n = 1'b0;
      #1;
      check("async_rgb",   int'(rgb),        0);
      check("async_hsync", int'(hsync),      0);
      check("async_vsync", int'(vsync),      0);
      check("async_level", int'(fade_level), 0);
      check("async_busy",  int'(busy),       0);
      step(2);
      rst_n = 1'b1;
      step(3);
      check("post_rst_lvl",  int'(fade_level), 0);
      check("post_rst_busy", int'(busy),       1);
      vsync_in = 1'b0;
      step(3);
      vsync_in = 1'b1;
      step(2);
      vsync_in = 1'b0;
      check("first_tick_lvl", int'(fade_level), 0);
      step(3);
      frame();
      check("second_tick_lvl", int'(fade_level), 1);

      // Fade back to hidden
      show = 1'b0;
      step(1);
      frames(3);
      check("final_lvl",  int'(fade_level), 0);
      check("final_busy", int'(busy),       0);
      step(2);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/overlay_mixer.md
OVERLAY_MIXER -- requirements
Module: overlay_mixer

Interface
REQ-001 The block SHALL provide parameter FRAMES_PER_STEP, default 4: frame ticks per fade step (legal range 1..15).
REQ-002 The block SHALL provide parameter KEY_COLOR, default 6'b100001: overlay transparency key.
REQ-003 The block SHALL have port clk, input, 1: pixel clock (the single clock).
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port hsync_in, input, 1: horizontal sync from the timing generator, high = pulse.
REQ-006 The block SHALL have port vsync_in, input, 1: vertical sync, high = pulse.
REQ-007 The block SHALL have port active_in, input, 1: visible-area flag aligned with the pixel inputs.
REQ-008 The block SHALL have port bg_rgb, input, 6: background pixel {R[1:0],G[1:0],B[1:0]}.
REQ-009 The block SHALL have port ov_rgb, input, 6: overlay (emblem) pixel in the same format; KEY_COLOR = transparent.
REQ-010 The block SHALL have port show, input, 1: level request, 1 = overlay visible, 0 = hidden.
REQ-011 The block SHALL have port rgb, output, 6: composited pixel, registered.
REQ-012 The block SHALL have port hsync, output, 1: hsync_in delayed to align with rgb.
REQ-013 The block SHALL have port vsync, output, 1: vsync_in delayed to align with rgb.
REQ-014 The block SHALL have port fade_level, output, 3: current blend level, 0..4.
REQ-015 The block SHALL have port busy, output, 1: high in FADE_IN or FADE_OUT.

Function
REQ-016 Frame tick SHALL be a one-cycle pulse on the 0->1 edge of vsync_in, detected against a registered copy of vsync_in.
REQ-017 The FSM SHALL have states HIDDEN, FADE_IN, SHOWN, FADE_OUT.
REQ-018 HIDDEN SHALL move to FADE_IN when show=1.
REQ-019 SHOWN SHALL move to FADE_OUT when show=0.
REQ-020 FADE_IN SHALL move to FADE_OUT when show=0, keeping the level.
REQ-021 FADE_OUT SHALL move to FADE_IN when show=1, keeping the level.
REQ-022 FADE_IN SHALL move to SHOWN when the level reaches 4.
REQ-023 FADE_OUT SHALL move to HIDDEN when the level reaches 0.
REQ-024 A 4-bit frame counter SHALL clear on every state change.
REQ-025 In FADE states the frame counter SHALL increment on each frame tick; when it reaches FRAMES_PER_STEP-1 on a tick, it SHALL clear and the level SHALL step by +/-1 on that same tick.
REQ-026 The level SHALL change only on a frame tick; it SHALL never change mid-frame.
REQ-027 A state change coinciding with a frame tick SHALL take the transition and SHALL NOT step the level in that cycle.
REQ-028 The level SHALL saturate within 0..4; no wrap-around.
REQ-029 Pixel path: when active_in=0, next rgb SHALL be 6'b000000.
REQ-030 Pixel path: when ov_rgb==KEY_COLOR or level==0, next rgb SHALL be bg_rgb.
REQ-031 Pixel path: otherwise, each 2-bit channel SHALL be (ov*level + bg*(4-level)) >> 2, computed at 5-bit width, truncated (no rounding).
REQ-032 At level 4 the blend SHALL equal ov_rgb exactly.
REQ-033 Latency SHALL be exactly 1 clock from inputs to rgb/hsync/vsync.
REQ-034 The blend SHALL use the level value held in the cycle the pixel is sampled.

Reset
REQ-035 On rst_n=0 (asynchronous): state=HIDDEN, level=0, frame counter=0, vsync history=0, rgb=0, hsync=0, vsync=0, busy=0.
REQ-036 Reset mid-fade SHALL abort immediately; after release the block SHALL behave as from power-up, with the next frame tick requiring a fresh 0->1 vsync edge.

Structure
REQ-037 Shared package/include overlay_pkg SHALL hold color constants (KEY_COLOR, BLACK, WHITE, GOLD, RED) and the FSM state encoding.
REQ-038 A combinational sub-module channel_blend (2-bit ov, 2-bit bg, 3-bit level -> 2-bit out) SHALL be instantiated three times.
REQ-039 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-040 Reset, show=0, active_in=1, bg=6'b000011, ov=6'b110110 -> rgb=6'b000011 one cycle later; fade_level=0; busy=0.
REQ-041 FRAMES_PER_STEP=2, show held 1, 10 vsync pulses -> level 1,2,3,4 after ticks 2,4,6,8; SHOWN; busy=0 after tick 8.
REQ-042 Level 2, bg=6'b000000, ov=6'b111111 -> rgb=6'b010101; ov=KEY_COLOR -> rgb=bg.
REQ-043 Level 3 in FADE_IN, drop show -> FADE_OUT with level still 3; subsequent steps 2,1,0; then HIDDEN.
REQ-044 active_in=0 with ov=6'b111111 at level 4 -> rgb=0; hsync/vsync track inputs with exactly 1-cycle delay.
REQ-045 Assert rst_n=0 at level 2 mid-frame -> all outputs 0 on the next sampling edge without a clock edge; with vsync_in held high through release, no tick until vsync falls and rises again.
